// File: rtl/ws2812_frame_sequencer.sv
// Frame sequencer for a WS2812 bit controller: fetches NUM_LEDS pixels, streams each word, then holds the latch gap.
// Optional macro WS2812_AUTO_REFRESH_EN: frames repeat back-to-back after the first Start.
module ws2812_frame_sequencer #(
  parameter int F_CLK      = 12_000_000,
  parameter int NUM_LEDS   = 8,
  parameter int BITWIDTH   = 24,
  parameter int T_LATCH_US = 60,
  parameter int FETCH_MAX  = 64
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Start,
  input  logic                PixelValid,
  input  logic [BITWIDTH-1:0] PixelData,
  input  logic                BitDone,
  output logic                PixelReq,
  output logic [7:0]          PixelAddr,
  output logic [BITWIDTH-1:0] BitData,
  output logic                BitReset,
  output logic                Busy,
  output logic                FrameDone,
  output logic                Underrun,
  output logic [1:0]          state_dbg
);

  // 64-bit product keeps large F_CLK * T_LATCH_US combinations from overflowing.
  localparam longint LATCH_L    = (longint'(T_LATCH_US) * longint'(F_CLK)) / 64'd1_000_000;
  localparam int     LATCH_CLKS = int'(LATCH_L);
  localparam int     LW         = (LATCH_CLKS > 1) ? $clog2(LATCH_CLKS) : 1;
  localparam int     FW         = $clog2(FETCH_MAX + 1);

  localparam logic [LW-1:0] LATCH_LAST  = LW'(LATCH_CLKS - 1);
  localparam logic [FW-1:0] FETCH_LIMIT = FW'(FETCH_MAX);
  localparam logic [FW-1:0] FETCH_PRE   = FW'(FETCH_MAX - 1);
  localparam logic [4:0]    BIT_LAST    = 5'(BITWIDTH - 1);
  localparam logic [7:0]    ADDR_LAST   = 8'(NUM_LEDS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, LATCH} state_t;

  state_t              state, state_n;
  logic                pixel_req_n, bit_reset_n, busy_n, frame_done_n, underrun_n;
  logic [7:0]          addr_n;
  logic [BITWIDTH-1:0] data_n;
  logic [4:0]          bit_cnt, bit_cnt_n;
  logic [FW-1:0]       fetch_cnt, fetch_cnt_n;
  logic [LW-1:0]       latch_cnt, latch_cnt_n;

  assign state_dbg = state;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      PixelReq  <= 1'b0;
      PixelAddr <= 8'd0;
      BitData   <= '0;
      BitReset  <= 1'b1;
      Busy      <= 1'b0;
      FrameDone <= 1'b0;
      Underrun  <= 1'b0;
      bit_cnt   <= 5'd0;
      fetch_cnt <= '0;
      latch_cnt <= '0;
    end else begin
      state     <= state_n;
      PixelReq  <= pixel_req_n;
      PixelAddr <= addr_n;
      BitData   <= data_n;
      BitReset  <= bit_reset_n;
      Busy      <= busy_n;
      FrameDone <= frame_done_n;
      Underrun  <= underrun_n;
      bit_cnt   <= bit_cnt_n;
      fetch_cnt <= fetch_cnt_n;
      latch_cnt <= latch_cnt_n;
    end
  end

  always_comb begin
    state_n      = state;
    pixel_req_n  = PixelReq;
    addr_n       = PixelAddr;
    data_n       = BitData;
    bit_reset_n  = BitReset;
    busy_n       = Busy;
    frame_done_n = 1'b0;
    underrun_n   = Underrun;
    bit_cnt_n    = bit_cnt;
    fetch_cnt_n  = fetch_cnt;
    latch_cnt_n  = latch_cnt;
    case (state)
      IDLE: begin
        bit_reset_n = 1'b1;
        busy_n      = 1'b0;
        pixel_req_n = 1'b0;
        // FrameDone is high in the first IDLE cycle; a Start there is dropped.
        if (Start && !FrameDone) begin
          state_n     = FETCH;
          addr_n      = 8'd0;
          underrun_n  = 1'b0;
          pixel_req_n = 1'b1;
          busy_n      = 1'b1;
          fetch_cnt_n = '0;
        end
      end
      FETCH: begin
        if (PixelReq && PixelValid) begin
          data_n      = PixelData;
          bit_cnt_n   = 5'd0;
          pixel_req_n = 1'b0;
          bit_reset_n = 1'b0;
          state_n     = SEND;
        end else if (fetch_cnt != FETCH_LIMIT) begin
          fetch_cnt_n = fetch_cnt + 1'b1;
          if (fetch_cnt == FETCH_PRE) underrun_n = 1'b1;
        end
      end
      SEND: begin
        if (BitDone) begin
          bit_cnt_n = bit_cnt + 5'd1;
          if (bit_cnt == BIT_LAST) begin
            bit_reset_n = 1'b1;
            if (PixelAddr < ADDR_LAST) begin
              addr_n      = PixelAddr + 8'd1;
              pixel_req_n = 1'b1;
              fetch_cnt_n = '0;
              state_n     = FETCH;
            end else begin
              latch_cnt_n = '0;
              state_n     = LATCH;
            end
          end
        end
      end
      LATCH: begin
        bit_reset_n = 1'b1;
        latch_cnt_n = latch_cnt + 1'b1;
        if (latch_cnt == LATCH_LAST) begin
          frame_done_n = 1'b1;
`ifdef WS2812_AUTO_REFRESH_EN
          state_n     = FETCH;
          addr_n      = 8'd0;
          pixel_req_n = 1'b1;
          fetch_cnt_n = '0;
`else
          state_n = IDLE;
          busy_n  = 1'b0;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
// Scoreboard bench for ws2812_frame_sequencer with NUM_LEDS=2: pixel loads and FrameDone pulses are
// matched by a negedge monitor against queues filled by the stimulus tasks.
module tb_ws2812_frame_sequencer;
  localparam int W = 32;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic        PixelValid = 1'b0;
  logic [23:0] PixelData = 24'd0;
  logic        BitDone = 1'b0;
  logic        PixelReq;
  logic [7:0]  PixelAddr;
  logic [23:0] BitData;
  logic        BitReset, Busy, FrameDone, Underrun;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int frame_id = 0;
  int frames_seen = 0;
  logic [W-1:0] exp_q[$];
  int done_q[$];

  ws2812_frame_sequencer #(.NUM_LEDS(2)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .PixelValid(PixelValid),
    .PixelData(PixelData), .BitDone(BitDone), .PixelReq(PixelReq),
    .PixelAddr(PixelAddr), .BitData(BitData), .BitReset(BitReset),
    .Busy(Busy), .FrameDone(FrameDone), .Underrun(Underrun), .state_dbg(state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_values();
    check("rst_bitreset", BitReset, 1);
    check("rst_pixelreq", PixelReq, 0);
    check("rst_addr", PixelAddr, 0);
    check("rst_bitdata", BitData, 0);
    check("rst_busy", Busy, 0);
    check("rst_framedone", FrameDone, 0);
    check("rst_underrun", Underrun, 0);
  endtask

  // ---------------- monitor ----------------
  logic prev_br = 1'b1;
  always @(negedge Clk) begin
    logic [W-1:0] e;
    int f;
    if (prev_br && !BitReset && !Reset) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL load_unexpected actual=%0h required=none", {PixelAddr, BitData});
      end else begin
        e = exp_q.pop_front();
        check("pixel_load", {PixelAddr, BitData}, e);
      end
    end
    if (FrameDone) begin
      frames_seen++;
      if (done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL framedone_unexpected actual=%0d required=none", frames_seen);
      end else begin
        f = done_q.pop_front();
        check("framedone_id", frames_seen, f);
      end
    end
    prev_br = BitReset;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic supply_pixel(input logic [7:0] addr, input logic [23:0] data);
    int n = 0;
    while (!PixelReq && n < 100) begin
      tick();
      n++;
    end
    check("pixelreq_seen", PixelReq, 1);
    PixelValid = 1'b1;
    PixelData  = data;
    exp_q.push_back({addr, data});
    tick();
    PixelValid = 1'b0;
  endtask

  task automatic send_bits(input int count);
    for (int i = 0; i < count; i++) begin
      BitDone = 1'b1;
      tick();
      BitDone = 1'b0;
      if (i != count - 1) tick();
    end
  endtask

  // Counts LATCH cycles up to FrameDone; optionally pulses Start at cycle start_at.
  task automatic wait_latch(input int start_at);
    int n = 0;
    frame_id++;
    done_q.push_back(frame_id);
    while (!FrameDone && n < 1000) begin
      Start = (n == start_at);
      tick();
      n++;
    end
    Start = 1'b0;
    check("latch_len", n, 720);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) tick();
    check_reset_values();
    Reset = 1'b0;
    tick();
    check("idle_busy", Busy, 0);

    // Basic frame
    pulse_start();
    check("start_busy", Busy, 1);
    check("start_pixelreq", PixelReq, 1);
    check("start_addr", PixelAddr, 0);
    supply_pixel(8'd0, 24'hA5C3F0);
    check("send_bitreset", BitReset, 0);
    send_bits(24);
    check("next_pixelreq", PixelReq, 1);
    check("next_addr", PixelAddr, 1);
    check("next_bitreset", BitReset, 1);
    supply_pixel(8'd1, 24'h123456);
    send_bits(24);
    check("latch_bitreset", BitReset, 1);
    wait_latch(-1);
`ifdef WS2812_AUTO_REFRESH_EN
    tick();
    check("auto_pixelreq", PixelReq, 1);
    check("auto_addr", PixelAddr, 0);
    check("auto_busy", Busy, 1);
    supply_pixel(8'd0, 24'h0F0F0F);
    send_bits(24);
    supply_pixel(8'd1, 24'hF0F0F0);
    send_bits(24);
    wait_latch(-1);
    tick();
    check("auto2_pixelreq", PixelReq, 1);
    check("auto2_addr", PixelAddr, 0);
    Reset = 1'b1;
    tick();
    check_reset_values();
`else
    check("done_busy", Busy, 0);
    tick();
    check("after_done_pulse", FrameDone, 0);
    check("after_done_pixelreq", PixelReq, 0);

    // Underrun: PixelValid withheld for 70 FETCH cycles
    pulse_start();
    check("ur_clear0", Underrun, 0);
    repeat (30) tick();
    check("ur_early", Underrun, 0);
    check("ur_bitreset_early", BitReset, 1);
    repeat (40) tick();
    check("ur_set", Underrun, 1);
    check("ur_bitreset", BitReset, 1);
    check("ur_still_fetch", PixelReq, 1);
    supply_pixel(8'd0, 24'hFFFFFF);
    send_bits(24);
    supply_pixel(8'd1, 24'h000001);
    send_bits(24);
    wait_latch(-1);
    check("ur_sticky", Underrun, 1);
    tick();

    // Ignored inputs: BitDone in IDLE/FETCH, Start in SEND/LATCH/FrameDone, stray PixelValid
    send_bits(3);
    check("idle_bitdone_busy", Busy, 0);
    pulse_start();
    check("ur_cleared", Underrun, 0);
    send_bits(3);
    check("fetch_bitdone_req", PixelReq, 1);
    check("fetch_bitdone_br", BitReset, 1);
    supply_pixel(8'd0, 24'h5A5A5A);
    send_bits(10);
    pulse_start();
    PixelValid = 1'b1;
    PixelData  = 24'hDEAD00;
    tick();
    PixelValid = 1'b0;
    check("stray_valid_data", BitData, 24'h5A5A5A);
    send_bits(14);
    check("pix1_addr", PixelAddr, 1);
    supply_pixel(8'd1, 24'hC0FFEE);
    send_bits(24);
    wait_latch(100);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("start_on_done_busy", Busy, 0);
    check("start_on_done_req", PixelReq, 0);

    // Reset mid-frame after 10 bits of pixel 1
    pulse_start();
    supply_pixel(8'd0, 24'h111111);
    send_bits(24);
    supply_pixel(8'd1, 24'h222222);
    send_bits(10);
    Reset = 1'b1;
    #2;
    check_reset_values();
    repeat (3) tick();
    Reset = 1'b0;
    repeat (800) tick();
    check("post_reset_busy", Busy, 0);
    check("post_reset_req", PixelReq, 0);
`endif

    check("exp_q_empty", exp_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ws2812_frame_sequencer.md
WS2812_FRAME_SEQUENCER -- requirements
Module: ws2812_frame_sequencer

Interface
REQ-001 SHALL have parameter F_CLK, default 12_000_000; clock frequency in Hz.
REQ-002 SHALL have parameter NUM_LEDS, default 8; pixels per frame, legal range 1..256.
REQ-003 SHALL have parameter BITWIDTH, default 24; bits per pixel.
REQ-004 SHALL have parameter T_LATCH_US, default 60; latch low time in us; LATCH_CLKS = T_LATCH_US*F_CLK/1_000_000, truncated (720 at defaults).
REQ-005 SHALL have parameter FETCH_MAX, default 64; FETCH cycles before underrun is flagged.
REQ-006 Clk  input  1  sole clock, rising edge.
REQ-007 Reset  input  1  asynchronous, active-high reset.
REQ-008 Start  input  1  one-cycle request to send one frame.
REQ-009 PixelValid  input  1  PixelData valid for PixelAddr.
REQ-010 PixelData  input  BITWIDTH  pixel word, transmitted MSB-first order as given to the bit controller.
REQ-011 BitDone  input  1  one-cycle pulse from the bit controller per completed bit.
REQ-012 PixelReq  output  1  pixel fetch request.
REQ-013 PixelAddr  output  8  index of pixel requested or being sent.
REQ-014 BitData  output  BITWIDTH  word driven to the bit controller Indata.
REQ-015 BitReset  output  1  holds the bit controller in reset (line low).
REQ-016 Busy  output  1  frame in progress.
REQ-017 FrameDone  output  1  one-cycle pulse at end of latch.
REQ-018 Underrun  output  1  sticky fetch-timeout flag.

Function
REQ-019 SHALL implement states IDLE, FETCH, SEND, LATCH; all outputs registered.
REQ-020 IDLE: BitReset=1, Busy=0, PixelReq=0; Start=1 -> FETCH, PixelAddr=0, Underrun cleared, PixelReq=1 next cycle.
REQ-021 Start outside IDLE SHALL be ignored; Start in the FrameDone cycle SHALL be ignored.
REQ-022 FETCH: PixelReq=1, BitReset=1; PixelValid=1 with PixelReq=1 SHALL load PixelData into BitData, clear bit count, drop PixelReq and BitReset, enter SEND, all on the same edge.
REQ-023 PixelValid while PixelReq=0 SHALL be ignored.
REQ-024 FETCH cycle counter reaching FETCH_MAX SHALL set Underrun=1; FETCH SHALL keep waiting for PixelValid.
REQ-025 SEND: each BitDone increments 5-bit bit count; BitDone outside SEND SHALL be ignored.
REQ-026 BitDone with count==BITWIDTH-1 and PixelAddr<NUM_LEDS-1: PixelAddr+1, BitReset=1, PixelReq=1, -> FETCH.
REQ-027 BitDone with count==BITWIDTH-1 and PixelAddr==NUM_LEDS-1: BitReset=1, latch counter=0, -> LATCH.
REQ-028 LATCH: BitReset=1; counter increments each cycle; at LATCH_CLKS-1 FrameDone=1 for one cycle, -> IDLE.
REQ-029 Busy SHALL be 1 in FETCH, SEND, LATCH.
REQ-030 BitData SHALL hold its value outside the FETCH->SEND load edge.

Reset
REQ-031 Reset SHALL asynchronously force IDLE, BitReset=1, PixelReq=0, PixelAddr=0, BitData=0, Busy=0, FrameDone=0, Underrun=0, all counters 0.
REQ-032 Reset mid-frame SHALL abandon the frame with no FrameDone; first edge after release behaves as IDLE.

Configuration
REQ-033 Macro WS2812_AUTO_REFRESH_EN defined: LATCH end SHALL pulse FrameDone and enter FETCH with PixelAddr=0 instead of IDLE; Start then only launches from IDLE after reset.
REQ-034 Macro undefined: one frame per accepted Start, per REQ-028.

Verification (NUM_LEDS=2, defaults otherwise)
REQ-035 Reset, Start, PixelValid held 1, 24 BitDone pulses per pixel -> PixelAddr 0 then 1, BitData equals each PixelData, 720 LATCH cycles, one FrameDone, Busy 0.
REQ-036 PixelValid withheld 70 cycles in FETCH -> Underrun=1 at cycle 64, BitReset stays 1, frame completes after PixelValid; next Start clears Underrun.
REQ-037 Start pulses during SEND and LATCH, BitDone pulses in IDLE/FETCH -> no state change, no extra FrameDone.
REQ-038 Reset asserted after 10 BitDone of pixel 1 -> outputs at reset values immediately (asynchronously), no FrameDone.
REQ-039 With WS2812_AUTO_REFRESH_EN, one Start -> FrameDone every frame, PixelReq with PixelAddr=0 the cycle after each FrameDone.
